// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the shared data memory.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface dmem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic        lock0;
    logic        lock1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        err0;
    logic        err1;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1,
        input  mem_read_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mem_write, mem_address, mem_write_data
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1,
        output mem_read_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two masters, with a bounded
// ownership lock for read-modify-write sequences and registered, range-checked responses.
module dmem_arbiter #(
    parameter int DEPTH    = 256,
    parameter int MAX_LOCK = 4
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int              CW         = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0]   LOCK_LIMIT = CW'(MAX_LOCK);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [30:0]     DEPTH_W    = 31'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_prio;
    logic          w_prio_next;
    logic [CW-1:0] r_lock_cnt;
    logic [CW-1:0] w_lock_cnt_next;

    logic [1:0]    w_req;
    logic [1:0]    w_we;
    logic [1:0]    w_lock;
    logic [1:0]    w_gnt;
    logic [1:0]    w_in_range;
    logic [31:0]   w_addr  [2];
    logic [31:0]   w_wdata [2];

    logic          w_arb;
    logic          w_owner;
    logic          w_winner;
    logic          w_mem_we;
    logic [31:0]   w_mem_addr;
    logic [31:0]   w_mem_wdata;
    logic          w_unused;

    assign w_req      = {bus.req1,  bus.req0};
    assign w_we       = {bus.we1,   bus.we0};
    assign w_lock     = {bus.lock1, bus.lock0};
    assign w_addr[0]  = bus.addr0;
    assign w_addr[1]  = bus.addr1;
    assign w_wdata[0] = bus.wdata0;
    assign w_wdata[1] = bus.wdata1;

    // Byte-offset bits carry no meaning for word accesses.
    assign w_unused = ^{w_addr[0][1:0], w_addr[1][1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_prio     <= w_prio_next;
            r_lock_cnt <= w_lock_cnt_next;
        end
    end

    always_comb begin
        w_gnt           = 2'b00;
        w_state_next    = r_state;
        w_prio_next     = r_prio;
        w_lock_cnt_next = r_lock_cnt;
        w_arb           = 1'b0;
        w_winner        = 1'b0;
        w_owner         = (r_state == LOCK1);

        case (r_state)
            IDLE: begin
                w_arb = 1'b1;
            end
            LOCK0, LOCK1: begin
                if (!w_req[w_owner]) begin
                    // Owner walked away: fall back to normal arbitration this same cycle.
                    w_arb = 1'b1;
                end else if (r_lock_cnt >= LOCK_LIMIT) begin
                    w_winner        = w_req[~w_owner] ? ~w_owner : w_owner;
                    w_gnt[w_winner] = 1'b1;
                    w_state_next    = IDLE;
                    w_lock_cnt_next = '0;
                end else if (w_lock[w_owner]) begin
                    w_winner        = w_owner;
                    w_gnt[w_winner] = 1'b1;
                    w_lock_cnt_next = r_lock_cnt + CNT_ONE;
                end else begin
                    w_winner        = w_owner;
                    w_gnt[w_winner] = 1'b1;
                    w_state_next    = IDLE;
                    w_lock_cnt_next = '0;
                end
            end
            default: begin
                w_arb = 1'b1;
            end
        endcase

        if (w_arb) begin
            w_state_next    = IDLE;
            w_lock_cnt_next = '0;
            if (|w_req) begin
                w_winner        = (&w_req) ? r_prio : w_req[1];
                w_gnt[w_winner] = 1'b1;
                if (w_lock[w_winner]) begin
                    w_state_next    = w_winner ? LOCK1 : LOCK0;
                    w_lock_cnt_next = CNT_ONE;
                end
            end
        end

        if (|w_gnt) begin
            w_prio_next = ~w_winner;
        end
    end

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        if (|w_gnt) begin
            w_mem_addr  = {w_addr[w_winner][31:2], 2'b00};
            w_mem_wdata = w_wdata[w_winner];
            w_mem_we    = w_we[w_winner] & w_in_range[w_winner] & rst_n;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic        r_rvalid;
            logic        r_err;
            logic [31:0] r_rdata;

            assign w_in_range[gi] = ({1'b0, w_addr[gi][31:2]} < DEPTH_W);

            // Memory read data belongs to this port only in the cycle it holds the grant.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                    r_rdata  <= '0;
                end else if (w_gnt[gi]) begin
                    r_rvalid <= 1'b1;
                    r_err    <= ~w_in_range[gi];
                    r_rdata  <= (!w_we[gi] && w_in_range[gi]) ? bus.mem_read_data : 32'h0;
                end else begin
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                    r_rdata  <= '0;
                end
            end
        end
    endgenerate

    assign bus.gnt0           = w_gnt[0];
    assign bus.gnt1           = w_gnt[1];
    assign bus.rvalid0        = g_port[0].r_rvalid;
    assign bus.rvalid1        = g_port[1].r_rvalid;
    assign bus.err0           = g_port[0].r_err;
    assign bus.err1           = g_port[1].r_err;
    assign bus.rdata0         = g_port[0].r_rdata;
    assign bus.rdata1         = g_port[1].r_rdata;
    assign bus.mem_write      = w_mem_we;
    assign bus.mem_address    = w_mem_addr;
    assign bus.mem_write_data = w_mem_wdata;
endmodule
